// File: rtl/prefetch_queue.sv
// prefetch_queue: byte-granular instruction prefetch queue.
// Issues word-aligned 32-bit code reads ahead of execution into a circular
// byte queue and presents a 16-byte window starting at o_eip to the decoder.
// Optional feature macro: PREFETCH_QUEUE_STATS_EN adds o_flush_count and
// o_starve_count statistics outputs.
module prefetch_queue #(
   parameter int          DEPTH_BYTES   = 32,
   parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_flush,
   input  logic [31:0] i_flush_address,
   output logic        o_code_vaild,
   input  logic        i_code_ready,
   output logic [31:0] o_code_address,
   input  logic [31:0] i_code_data_read,
   output logic [7:0]  o_instruction [0:15],
   output logic [4:0]  o_bytes_valid,
   output logic [31:0] o_eip,
   input  logic        i_consume,
   input  logic [4:0]  i_consume_count
`ifdef PREFETCH_QUEUE_STATS_EN
   ,
   output logic [15:0] o_flush_count,
   output logic [31:0] o_starve_count
`endif
);

   localparam int PW = $clog2(DEPTH_BYTES);
   localparam int CW = PW + 1;
   // Highest fill level that still leaves room for one full word.
   localparam logic [CW-1:0] REQ_LIMIT = CW'(DEPTH_BYTES - 4);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

   state_t          state, state_next;
   logic [7:0]      queue [DEPTH_BYTES];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, count_next, written;
   logic [31:0]     fetch_addr;   // address of the next word to request
   logic [31:0]     drain_addr;   // address of the abandoned request while draining
   logic [1:0]      skip;         // leading bytes of the next word that are discarded
   logic [2:0]      wr_bytes;
   logic            accept;
   logic [4:0]      consume_n;
   logic [3:0]      wr_en;
   logic [PW-1:0]   wr_idx [4];

   // A returning word is kept only in REQ and only when no flush overrides it.
   assign accept     = (state == REQ) && i_code_ready && !i_flush;
   assign wr_bytes   = 3'd4 - {1'b0, skip};
   assign written    = accept ? CW'(wr_bytes) : '0;
   assign o_bytes_valid = (count >= CW'(16)) ? 5'd16 : count[4:0];
   assign consume_n  = !i_consume ? 5'd0 :
                       (i_consume_count < o_bytes_valid) ? i_consume_count : o_bytes_valid;
   assign count_next = count + written - CW'(consume_n);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic: flush dominates; a request left hanging must be drained.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
      state_next = state;
      if (i_flush) begin
         state_next = ((state != IDLE) && !i_code_ready) ? DRAIN : REQ;
      end else begin
         case (state)
            IDLE:    if (count <= REQ_LIMIT) state_next = REQ;
            REQ:     if (i_code_ready) state_next = (count_next <= REQ_LIMIT) ? REQ : IDLE;
            DRAIN:   if (i_code_ready) state_next = REQ;
            default: state_next = IDLE;
         endcase
      end
   end

   // Bus request outputs: draining keeps presenting the old address.
   always_comb begin
      o_code_vaild   = (state != IDLE);
      o_code_address = (state == DRAIN) ? drain_addr : fetch_addr;
   end

   // Queue pointers, fill count, instruction pointer and fetch address.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         o_eip      <= RESET_ADDRESS;
         fetch_addr <= RESET_ADDRESS & ~32'd3;
         drain_addr <= RESET_ADDRESS & ~32'd3;
         skip       <= RESET_ADDRESS[1:0];
      end else if (i_flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         o_eip      <= i_flush_address;
         fetch_addr <= i_flush_address & ~32'd3;
         skip       <= i_flush_address[1:0];
         // Capture the in-flight address only when entering DRAIN from REQ;
         // a repeated flush while draining keeps the original one.
         if ((state == REQ) && !i_code_ready) drain_addr <= fetch_addr;
      end else begin
         rd_ptr <= rd_ptr + PW'(consume_n);
         o_eip  <= o_eip + 32'(consume_n);
         count  <= count_next;
         if (accept) begin
            wr_ptr     <= wr_ptr + PW'(wr_bytes);
            fetch_addr <= fetch_addr + 32'd4;
            skip       <= 2'd0;
         end
      end
   end

   // Byte lanes of the returning word that land in the queue, packed at wr_ptr.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         wr_en[j]  = accept && (2'(j) >= skip);
         wr_idx[j] = wr_ptr + PW'(j) - PW'(skip);
      end
   end

   // Queue storage write.
   always_ff @(posedge clock) begin
      // NOTE: the byte array is not reset; count gates every read, so stale bytes are never visible.
      for (int j = 0; j < 4; j++) begin
         if (wr_en[j]) queue[wr_idx[j]] <= i_code_data_read[8*j +: 8];
      end
   end

   // Decoder window: bytes beyond the valid count read as zero.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         o_instruction[i] = (5'(i) < o_bytes_valid) ? queue[rd_ptr + PW'(i)] : 8'h00;
      end
   end

`ifdef PREFETCH_QUEUE_STATS_EN
   // Statistics: saturating flush counter and wrapping starvation counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         o_flush_count  <= '0;
         o_starve_count <= '0;
      end else begin
         if (i_flush && (o_flush_count != 16'hFFFF)) o_flush_count <= o_flush_count + 16'd1;
         if ((o_bytes_valid == 5'd0) && (state != IDLE)) o_starve_count <= o_starve_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed self-checking bench for prefetch_queue.
// A byte scoreboard is filled as code words are delivered and drained as the
// decoder consumes; the DUT window is compared against its front.
// A second instance with RESET_ADDRESS FFFF_FFFC covers the wrap/clamp case.
module tb_prefetch_queue;

   logic        clock = 1'b0;
   logic        reset;
   always #5 clock = ~clock;

   // Instance 1 signals
   logic        flush;
   logic [31:0] flush_address;
   logic        code_vaild;
   logic        code_ready;
   logic [31:0] code_address;
   logic [31:0] code_data;
   logic [7:0]  instruction [0:15];
   logic [4:0]  bytes_valid;
   logic [31:0] eip;
   logic        consume;
   logic [4:0]  consume_count;

   // Instance 2 signals
   logic        flush_2;
   logic [31:0] flush_address_2;
   logic        code_vaild_2;
   logic        code_ready_2;
   logic [31:0] code_address_2;
   logic [31:0] code_data_2;
   logic [7:0]  instruction_2 [0:15];
   logic [4:0]  bytes_valid_2;
   logic [31:0] eip_2;
   logic        consume_2;
   logic [4:0]  consume_count_2;

`ifdef PREFETCH_QUEUE_STATS_EN
   logic [15:0] flush_count, flush_count_2;
   logic [31:0] starve_count, starve_count_2;
`endif

   prefetch_queue #(.DEPTH_BYTES(32), .RESET_ADDRESS(32'hFFFF_FFF0)) u_dut (
      .clock(clock), .reset(reset),
      .i_flush(flush), .i_flush_address(flush_address),
      .o_code_vaild(code_vaild), .i_code_ready(code_ready),
      .o_code_address(code_address), .i_code_data_read(code_data),
      .o_instruction(instruction), .o_bytes_valid(bytes_valid), .o_eip(eip),
      .i_consume(consume), .i_consume_count(consume_count)
`ifdef PREFETCH_QUEUE_STATS_EN
      , .o_flush_count(flush_count), .o_starve_count(starve_count)
`endif
   );

   prefetch_queue #(.DEPTH_BYTES(32), .RESET_ADDRESS(32'hFFFF_FFFC)) u_dut_2 (
      .clock(clock), .reset(reset),
      .i_flush(flush_2), .i_flush_address(flush_address_2),
      .o_code_vaild(code_vaild_2), .i_code_ready(code_ready_2),
      .o_code_address(code_address_2), .i_code_data_read(code_data_2),
      .o_instruction(instruction_2), .o_bytes_valid(bytes_valid_2), .o_eip(eip_2),
      .i_consume(consume_2), .i_consume_count(consume_count_2)
`ifdef PREFETCH_QUEUE_STATS_EN
      , .o_flush_count(flush_count_2), .o_starve_count(starve_count_2)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: bytes expected in the window, in order, plus model pointers.
   logic [7:0]  exp_q [$];
   logic [31:0] m_eip;
   logic [31:0] m_fetch;
   logic [1:0]  m_skip;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the active edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int avail();
      return (exp_q.size() > 16) ? 16 : exp_q.size();
   endfunction

   task automatic check_window(input string tag);
      int nv;
      nv = avail();
      check({tag, ".valid"}, 32'(bytes_valid), 32'(nv));
      check({tag, ".eip"}, eip, m_eip);
      for (int i = 0; i < 16; i++)
         check($sformatf("%s.byte%0d", tag, i), 32'(instruction[i]),
               (i < nv) ? 32'(exp_q[i]) : 32'h0);
   endtask

   // Deliver one code word (optionally consuming in the same cycle).
   task automatic give_word(input logic [31:0] data, input int n_consume);
      int k;
      check("req.vaild", 32'(code_vaild), 32'd1);
      check("req.addr", code_address, m_fetch);
      k = (n_consume < avail()) ? n_consume : avail();
      code_ready = 1'b1; code_data = data;
      consume = (n_consume != 0); consume_count = 5'(n_consume);
      tick();
      code_ready = 1'b0; consume = 1'b0; consume_count = 5'd0;
      repeat (k) void'(exp_q.pop_front());
      m_eip = m_eip + 32'(k);
      for (int j = int'(m_skip); j < 4; j++) exp_q.push_back(data[8*j +: 8]);
      m_skip  = 2'd0;
      m_fetch = m_fetch + 32'd4;
   endtask

   task automatic do_consume(input int n);
      int k;
      k = (n < avail()) ? n : avail();
      consume = 1'b1; consume_count = 5'(n);
      tick();
      consume = 1'b0; consume_count = 5'd0;
      repeat (k) void'(exp_q.pop_front());
      m_eip = m_eip + 32'(k);
   endtask

   // Flush with a competing consume and optional ready, both of which must be ignored.
   task automatic do_flush(input logic [31:0] addr, input logic with_ready);
      flush = 1'b1; flush_address = addr;
      code_ready = with_ready; code_data = 32'hDEAD_BEEF;
      consume = 1'b1; consume_count = 5'd5;
      tick();
      flush = 1'b0; code_ready = 1'b0; consume = 1'b0; consume_count = 5'd0;
      exp_q.delete();
      m_eip   = addr;
      m_fetch = addr & ~32'd3;
      m_skip  = addr[1:0];
   endtask

   initial begin
      flush = 0; flush_address = 0; code_ready = 0; code_data = 0;
      consume = 0; consume_count = 0;
      flush_2 = 0; flush_address_2 = 0; code_ready_2 = 0; code_data_2 = 0;
      consume_2 = 0; consume_count_2 = 0;
      m_eip = 32'hFFFF_FFF0; m_fetch = 32'hFFFF_FFF0; m_skip = 2'd0;

      // Reset values
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check("rst.vaild", 32'(code_vaild), 32'd0);
      check("rst.addr", code_address, 32'hFFFF_FFF0);
      check_window("rst");
      check("rst2.vaild", 32'(code_vaild_2), 32'd0);
      check("rst2.addr", code_address_2, 32'hFFFF_FFFC);
      check("rst2.eip", eip_2, 32'hFFFF_FFFC);

      // Request rises one cycle after reset; address held while waiting
      tick();
      check("lat.vaild", 32'(code_vaild), 32'd1);
      check("lat.addr", code_address, 32'hFFFF_FFF0);
      tick();
      check("hold.addr", code_address, 32'hFFFF_FFF0);
      give_word(32'h4433_2211, 0);
      check_window("t1");
      check("t1.b0", 32'(instruction[0]), 32'h11);
      check("t1.b3", 32'(instruction[3]), 32'h44);
      check("t1.next", code_address, 32'hFFFF_FFF4);

      // Fill to capacity; fetch address wraps through 0000_0000
      for (int w = 0; w < 7; w++) give_word($urandom, 0);
      check("full.vaild", 32'(code_vaild), 32'd0);
      check("full.valid", 32'(bytes_valid), 32'd16);
      check_window("full");
      tick();
      check("full.idle", 32'(code_vaild), 32'd0);

      // Consume 16 -> count 16; request resumes the following cycle
      do_consume(16);
      check("c16.vaild", 32'(code_vaild), 32'd0);
      check_window("c16");
      check("c16.eip", eip, 32'h0000_0000);
      tick();
      check("c16.rise", 32'(code_vaild), 32'd1);

      // Word arrives while consuming 3 -> count 17
      give_word($urandom, 3);
      check_window("wc");
      do_consume(16);
      check("wc.rest", 32'(bytes_valid), 32'd1);
      check_window("wc2");
      do_consume(0);
      check_window("zero");

      // Flush with simultaneous ready (dropped) to 0000_1002
      do_flush(32'h0000_1002, 1'b1);
      check("fl.vaild", 32'(code_vaild), 32'd1);
      check("fl.addr", code_address, 32'h0000_1000);
      check_window("fl");
      give_word(32'hDDCC_BBAA, 0);
      check("fl.valid", 32'(bytes_valid), 32'd2);
      check("fl.b0", 32'(instruction[0]), 32'hCC);
      check("fl.b1", 32'(instruction[1]), 32'hDD);
      check("fl.eip", eip, 32'h0000_1002);
      check_window("fl2");

      // Flush with a request outstanding -> drain the old word
      do_flush(32'h0000_2000, 1'b0);
      check("dr.vaild", 32'(code_vaild), 32'd1);
      check("dr.addr", code_address, 32'h0000_1004);
      check_window("dr");
      tick();
      check("dr.hold", code_address, 32'h0000_1004);
      check("dr.valid", 32'(bytes_valid), 32'd0);
      code_ready = 1'b1; code_data = 32'h1234_5678;
      tick();
      code_ready = 1'b0;
      check("dr.drop", 32'(bytes_valid), 32'd0);
      check("dr.new", code_address, 32'h0000_2000);
      give_word(32'h8877_6655, 0);
      check_window("dr2");

      // Second instance: address wrap and consume clamp
      check("w.vaild", 32'(code_vaild_2), 32'd1);
      check("w.addr", code_address_2, 32'hFFFF_FFFC);
      code_ready_2 = 1'b1; code_data_2 = 32'h0403_0201;
      tick();
      code_ready_2 = 1'b0;
      check("w.valid", 32'(bytes_valid_2), 32'd4);
      check("w.b0", 32'(instruction_2[0]), 32'h01);
      check("w.b3", 32'(instruction_2[3]), 32'h04);
      check("w.next", code_address_2, 32'h0000_0000);
      consume_2 = 1'b1; consume_count_2 = 5'd5;
      tick();
      consume_2 = 1'b0; consume_count_2 = 5'd0;
      check("w.clamp", 32'(bytes_valid_2), 32'd0);
      check("w.eip", eip_2, 32'h0000_0000);

`ifdef PREFETCH_QUEUE_STATS_EN
      check("st.flush", 32'(flush_count), 32'd2);
`endif

      // Asynchronous reset mid-transfer
      #2 reset = 1'b1;
      #1;
      check("ar.vaild", 32'(code_vaild), 32'd0);
      check("ar.valid", 32'(bytes_valid), 32'd0);
      check("ar.eip", eip, 32'hFFFF_FFF0);
      check("ar.addr", code_address, 32'hFFFF_FFF0);
      tick();
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
